// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte-stream requesters.
// A grant is locked for a packet; it ends on last byte, burst limit or idle timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_REQ*8-1:0]       req_byte_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  input  logic [NUM_REQ-1:0]         req_last_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  output logic [7:0]                 tx_byte_out,
  output logic                       tx_valid_out,
  input  logic                       tx_ready_in,
  output logic [NUM_REQ-1:0]         grant_out,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_out,
  output logic                       busy_out
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int IC_W = $clog2(IDLE_TIMEOUT);
  localparam logic [7:0]      BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [IC_W-1:0] IDLE_LAST  = IC_W'(IDLE_TIMEOUT - 1);
  localparam logic [IC_W-1:0] IDLE_MAX   = '1;
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [7:0]      burst_cnt;
  logic [IC_W-1:0] idle_cnt;

  logic            owner_valid;
  logic            owner_last;
  logic [7:0]      owner_byte;
  logic            owner_ready;
  logic            accept;
  logic            release_now;
  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] next_ptr;

  assign owner_valid = req_valid_in[grant_id_out];
  assign owner_last  = req_last_in[grant_id_out];
  assign owner_byte  = req_byte_in[{grant_id_out, 3'b000} +: 8];
  assign owner_ready = (state == LOCKED) && (!tx_valid_out || tx_ready_in);
  assign accept      = owner_ready && owner_valid;
  assign next_ptr    = (grant_id_out == LAST_ID) ? '0 : grant_id_out + 1'b1;
  assign busy_out    = (state == LOCKED) || tx_valid_out;

  // The owner may only push when the output register is empty or draining this cycle.
  always_comb begin
    req_ready_out = '0;
    if (state == LOCKED) req_ready_out[grant_id_out] = !tx_valid_out || tx_ready_in;
  end

  assign release_now = (state == LOCKED) &&
                       ((accept && (owner_last || burst_cnt == BURST_LAST)) ||
                        (!owner_valid && idle_cnt == IDLE_LAST));

  always_comb begin : rr_pick
    int idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req_valid_in[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      idle_cnt     <= '0;
      tx_byte_out  <= '0;
      tx_valid_out <= 1'b0;
      grant_out    <= '0;
      grant_id_out <= '0;
    end else begin
      if (accept) begin
        tx_byte_out  <= owner_byte;
        tx_valid_out <= 1'b1;
      end else if (tx_valid_out && tx_ready_in) begin
        tx_valid_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            state        <= LOCKED;
            grant_out    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
            grant_id_out <= pick_id;
            burst_cnt    <= '0;
            idle_cnt     <= '0;
          end
        end
        LOCKED: begin
          if (accept) begin
            burst_cnt <= burst_cnt + 8'd1;
            idle_cnt  <= '0;
          end else if (!owner_valid && idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          // grant_id_out deliberately keeps the previous owner after release.
          if (release_now) begin
            state     <= IDLE;
            rr_ptr    <= next_ptr;
            grant_out <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios plus randomized packet rounds
// checked against a queue-level round-robin/burst model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int IT = 8;

  logic           clk_100mhz = 1'b0;
  logic           rst_n;
  logic [N*8-1:0] req_byte;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_byte;
  logic           tx_valid;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic [1:0]     grant_id;
  logic           busy;

  int total = 0;
  int bad   = 0;

  // Entry layout: [9] gap allowed after this byte, [8] last, [7:0] data.
  logic [9:0] req_q   [N][$];
  logic [9:0] model_q [N][$];
  logic [7:0] exp_q   [$];
  int         gap_cnt [N];
  int         tx_ready_pct = 100;
  bit         gap_en = 1'b0;
  int         model_ptr = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
    .clk_in        (clk_100mhz),
    .rst_n_in      (rst_n),
    .req_byte_in   (req_byte),
    .req_valid_in  (req_valid),
    .req_last_in   (req_last),
    .req_ready_out (req_ready),
    .tx_byte_out   (tx_byte),
    .tx_valid_out  (tx_valid),
    .tx_ready_in   (tx_ready),
    .grant_out     (grant),
    .grant_id_out  (grant_id),
    .busy_out      (busy)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=timeout expected=event", name);
  endtask

  // Requester and uart_tx drivers: handshakes are decided at negedge, inputs move at posedge+1.
  always begin : driver
    logic [9:0] e;
    @(negedge clk_100mhz);
    for (int i = 0; i < N; i++) begin
      if (rst_n && req_valid[i] && req_ready[i] && req_q[i].size() > 0) begin
        e = req_q[i].pop_front();
        if (gap_en && e[9] && !e[8]) gap_cnt[i] = int'($urandom_range(0, 5));
      end
    end
    @(posedge clk_100mhz);
    #1;
    for (int i = 0; i < N; i++) begin
      if (gap_cnt[i] > 0) begin
        req_valid[i] = 1'b0;
        gap_cnt[i]--;
      end else if (req_q[i].size() > 0) begin
        e = req_q[i][0];
        req_valid[i]       = 1'b1;
        req_byte[i*8 +: 8] = e[7:0];
        req_last[i]        = e[8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
    tx_ready = ($urandom_range(0, 99) < tx_ready_pct);
  end

  // Monitor: every byte taken by uart_tx is compared with the scoreboard head.
  always @(negedge clk_100mhz) begin : monitor
    logic [7:0] want;
    if (rst_n === 1'b1 && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL tx_unexpected actual=0x%0h expected=none", tx_byte);
      end else begin
        want = exp_q.pop_front();
        checkOutput("tx_byte", 32'(tx_byte), 32'(want));
      end
    end
  end

  function automatic bit allEmpty();
    bit r = 1'b1;
    for (int i = 0; i < N; i++) if (req_q[i].size() > 0) r = 1'b0;
    return r;
  endfunction

  task automatic pushByte(input int r, input logic [7:0] b, input bit last, input bit expect_out);
    req_q[r].push_back({1'b0, last, b});
    if (expect_out) exp_q.push_back(b);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int  c = 0;
    bit  done = 1'b0;
    while (!done && c < budget) begin
      @(negedge clk_100mhz);
      c++;
      done = (exp_q.size() == 0) && !busy && allEmpty();
    end
    if (!done) timeoutFail(name);
  endtask

  task automatic waitGrant(input string name, input logic [N-1:0] want);
    int c = 0;
    while (grant == '0 && c < 100) begin
      @(negedge clk_100mhz);
      c++;
    end
    if (grant == '0) timeoutFail(name);
    else checkOutput(name, 32'(grant), 32'(want));
  endtask

  task automatic waitRelease(input string name);
    int c = 0;
    while (grant != '0 && c < 200) begin
      @(negedge clk_100mhz);
      c++;
    end
    if (grant != '0) timeoutFail(name);
  endtask

  task automatic countLock(input logic [N-1:0] want, output int cnt);
    cnt = 0;
    while (grant == want && cnt < 200) begin
      cnt++;
      @(negedge clk_100mhz);
    end
  endtask

  // Random round: load packets, then derive the expected byte order from queue-level rules.
  task automatic applyStimulus();
    int         npk, len, g, n, idx;
    logic [7:0] b;
    logic [9:0] ent;
    bit         stop;
    for (int i = 0; i < N; i++) begin
      npk = int'($urandom_range(1, 3));
      for (int p = 0; p < npk; p++) begin
        len = int'($urandom_range(1, 24));
        for (int k = 0; k < len; k++) begin
          b   = 8'($urandom);
          ent = {(len <= MB), (k == len - 1), b};
          req_q[i].push_back(ent);
          model_q[i].push_back(ent);
        end
      end
    end
    g = 0;
    while (g >= 0) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (model_ptr + k) % N;
        if (g < 0 && model_q[idx].size() > 0) g = idx;
      end
      if (g >= 0) begin
        n    = 0;
        stop = 1'b0;
        while (!stop) begin
          ent = model_q[g].pop_front();
          exp_q.push_back(ent[7:0]);
          n++;
          stop = ent[8] || n == MB || model_q[g].size() == 0;
        end
        model_ptr = (g + 1) % N;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cnt;
    int c;
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_byte  = '0;
    tx_ready  = 1'b0;
    for (int i = 0; i < N; i++) gap_cnt[i] = 0;
    #1;
    checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset_tx_byte", 32'(tx_byte), 32'd0);
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk_100mhz);
    rst_n = 1'b1;

    $display("[TB] idle after reset");
    repeat (20) @(negedge clk_100mhz);
    checkOutput("idle_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("idle_grant", 32'(grant), 32'd0);
    checkOutput("idle_ready", 32'(req_ready), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] req1 three-byte packet");
    @(negedge clk_100mhz); #1;
    pushByte(1, 8'h41, 1'b0, 1'b1);
    pushByte(1, 8'h42, 1'b0, 1'b1);
    pushByte(1, 8'h43, 1'b1, 1'b1);
    c = 0;
    do begin
      @(negedge clk_100mhz);
      c++;
    end while (!req_valid[1] && c < 20);
    @(negedge clk_100mhz);
    checkOutput("grant_latency", 32'(grant), 32'b0010);
    checkOutput("grant_id_req1", 32'(grant_id), 32'd1);
    countLock(4'b0010, cnt);
    checkOutput("req1_lock_cycles", 32'(cnt), 32'd3);
    checkOutput("grant_id_hold", 32'(grant_id), 32'd1);
    waitDrain("req1_drain", 50);

    $display("[TB] req3 under backpressure");
    @(negedge clk_100mhz); #1;
    tx_ready_pct = 0;
    for (int k = 0; k < 5; k++) pushByte(3, 8'(8'h60 + k), (k == 4), 1'b1);
    waitGrant("req3_grant", 4'b1000);
    c = 0;
    while (!tx_valid && c < 20) begin
      @(negedge clk_100mhz);
      c++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_100mhz);
      checkOutput("bp_tx_byte_stable", 32'(tx_byte), 32'h60);
      checkOutput("bp_ready3_low", 32'(req_ready[3]), 32'd0);
    end
    checkOutput("bp_tx_valid", 32'(tx_valid), 32'd1);
    tx_ready_pct = 100;
    waitDrain("req3_drain", 50);

    $display("[TB] req0 and req2 round robin");
    @(negedge clk_100mhz); #1;
    pushByte(0, 8'h10, 1'b1, 1'b1);
    pushByte(2, 8'h20, 1'b1, 1'b1);
    waitGrant("rr_first_req0", 4'b0001);
    waitRelease("rr_release_req0");
    waitGrant("rr_second_req2", 4'b0100);
    waitDrain("rr_drain", 50);
    @(negedge clk_100mhz); #1;
    pushByte(0, 8'h11, 1'b1, 1'b1);
    waitGrant("rr_req0_again", 4'b0001);
    waitDrain("rr_drain2", 50);

    $display("[TB] idle timeout");
    @(negedge clk_100mhz); #1;
    pushByte(1, 8'h30, 1'b0, 1'b1);
    pushByte(0, 8'h31, 1'b1, 1'b1);
    waitGrant("timeout_first_owner", 4'b0010);
    countLock(4'b0010, cnt);
    checkOutput("timeout_lock_cycles", 32'(cnt), 32'(1 + IT));
    waitGrant("timeout_next_owner", 4'b0001);
    waitDrain("timeout_drain", 50);

    $display("[TB] async reset mid-packet");
    @(negedge clk_100mhz); #1;
    tx_ready_pct = 0;
    for (int k = 0; k < 6; k++) pushByte(2, 8'(8'h50 + k), (k == 5), 1'b0);
    c = 0;
    while (!tx_valid && c < 20) begin
      @(negedge clk_100mhz);
      c++;
    end
    checkOutput("pre_reset_tx_valid", 32'(tx_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("async_grant", 32'(grant), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    for (int i = 0; i < N; i++) begin
      req_q[i].delete();
      gap_cnt[i] = 0;
    end
    exp_q.delete();
    tx_ready_pct = 100;
    repeat (2) @(negedge clk_100mhz);
    rst_n = 1'b1;
    model_ptr = 0;

    for (int r = 0; r < 3; r++) begin
      $display("[TB] random round %0d", r);
      @(negedge clk_100mhz); #1;
      tx_ready_pct = 100 - 30 * r;
      gap_en = 1'b1;
      applyStimulus();
      waitDrain("random_drain", 4000);
      checkOutput("random_end_grant", 32'(grant), 32'd0);
      checkOutput("random_end_tx_valid", 32'(tx_valid), 32'd0);
    end
    gap_en = 1'b0;

    repeat (3) @(negedge clk_100mhz);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters, e.g. echo path, status reporter and debug dump.
- Uses round-robin arbitration with packet locking: a grant is held until the requester marks its last byte, the burst limit is reached, or the requester goes silent.
- Sits between the requester logic and the uart_tx serializer, and presents a single registered valid/ready byte stream to it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, max bytes per grant before forced release (1..255).
- IDLE_TIMEOUT, 1024, cycles a locked requester may hold the grant with req_valid_in low before forced release (>=2).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- req_byte_in  input  NUM_REQ*8  requester bytes; requester i on bits [8i+7:8i].
- req_valid_in  input  NUM_REQ  byte valid per requester.
- req_last_in  input  NUM_REQ  byte is last of packet; qualified by valid.
- req_ready_out  output  NUM_REQ  byte accepted when valid&ready.
- tx_byte_out  output  8  byte to uart_tx.
- tx_valid_out  output  1  tx_byte_out holds an unsent byte.
- tx_ready_in  input  1  uart_tx accepts the byte this cycle (idle).
- grant_out  output  NUM_REQ  one-hot current owner; all zero when unlocked.
- grant_id_out  output  $clog2(NUM_REQ)  index of current or last owner.
- busy_out  output  1  locked or tx_valid_out high.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; rr_ptr=0; burst_cnt=0; idle_cnt=0.
  - tx_byte_out=0, tx_valid_out=0, req_ready_out=0, grant_out=0, grant_id_out=0, busy_out=0.
  - Reset mid-packet drops the in-flight output byte and the grant silently.
- States: IDLE, LOCKED.
- IDLE:
  - If any req_valid_in bit is set, pick the first set bit scanning upward from rr_ptr with wrap.
  - Next cycle: LOCKED, grant_out/grant_id_out = winner, burst_cnt=0, idle_cnt=0.
  - req_ready_out is all zero in IDLE.
- LOCKED, owner g:
  - req_ready_out[g] = !tx_valid_out || tx_ready_in. All other ready bits are 0.
  - On accept (req_valid_in[g] & req_ready_out[g]): tx_byte_out <= byte, tx_valid_out <= 1, burst_cnt++, idle_cnt=0.
  - Release to IDLE next cycle if the accepted byte has req_last_in[g]=1, or if burst_cnt==MAX_BURST-1 at the accept.
  - If req_valid_in[g]=0: idle_cnt++. At idle_cnt==IDLE_TIMEOUT-1, release.
  - On any release: rr_ptr <= (g+1) mod NUM_REQ; grant_out <= 0; grant_id_out holds g.
- Output register:
  - tx_valid_out clears on tx_valid_out & tx_ready_in with no same-cycle accept.
  - A simultaneous drain and accept keeps it set and loads the new byte, giving full throughput.
  - tx_byte_out is stable while tx_valid_out=1 and tx_ready_in=0.
- Latency:
  - Request in IDLE at cycle n -> grant at n+1.
  - First byte accepted at n+1 if valid -> tx_valid_out at n+2.
  - Minimum gap between packets from different owners: one IDLE cycle.
- Release vs output register:
  - Arbitration proceeds while the last byte still sits in the output register.
  - The new owner's ready waits for the register to drain.
- Fairness: a requester that is continuously valid is granted within NUM_REQ-1 other grants.
- Reserved behaviour: the owner deasserting valid mid-packet keeps the lock until the timeout. Bytes never interleave between requesters.
- Width rules:
  - burst_cnt is 8 bits.
  - idle_cnt is $clog2(IDLE_TIMEOUT) bits and saturates; no wrap.
  - rr_ptr wraps modulo NUM_REQ, including non-power-of-2 NUM_REQ.

Test Plan:
- Reset, then all req_valid_in=0 for 20 cycles -> all outputs 0, state IDLE, busy_out=0.
- Req1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_ready_in=1 -> grant_out=0010 at cycle 1, tx bytes 0x41,0x42,0x43 on consecutive cycles, grant_out=0 after, rr_ptr=2.
- Req0 and req2 both valid, 1-byte packets, rr_ptr=0 -> req0 served first, then req2. Req0 re-requests -> req2's successor order holds: req3 idle, req0 next.
- tx_ready_in held low 10 cycles with req3 streaming -> one byte in the register, req_ready_out[3]=0, tx_byte_out stable. Raising tx_ready_in resumes one byte per cycle.
- Req2 streams 20 bytes with no last, MAX_BURST=16 -> release after byte 16 and rearbitration. Req2 regains the grant only after the other pending requesters are served.
- Req1 locked, sends 1 byte, then drops valid with IDLE_TIMEOUT=8 -> release 8 cycles later. Req0 pending is granted. Async rst_n_in low mid-packet -> tx_valid_out and grant_out drop to 0 immediately.
